// File: rtl/pipe_stage_buf_pkg.sv
// pipe_pkg: occupancy type, state constants and DEPTH legality check shared by the stage buffers.
package pipe_pkg;

    typedef logic [1:0] occ_t;

    localparam occ_t OCC_EMPTY = 2'd0;
    localparam occ_t OCC_ONE   = 2'd1;
    localparam occ_t OCC_FULL  = 2'd2;

    function automatic bit depth_ok(input int depth);
        return depth == 1 || depth == 2;
    endfunction

endpackage

// File: rtl/pipe_stage_buf_slot.sv
// pipe_slot: one WIDTH-bit payload entry with valid bit; clear wins over load and zeroes the payload.
module pipe_slot #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    output logic             valid,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (clear) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end

endmodule

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: valid/ready inter-stage buffer, plain register (DEPTH=1) or main+skid (DEPTH=2).
// Invalid entries always hold zero so a bubble decodes as a NOP downstream.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 2,
    parameter int STALL_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output occ_t               occupancy,
    output logic [STALL_W-1:0] stall_cycles
);

    logic             in_fire, out_fire;
    logic             main_valid, main_load, main_clear;
    logic             skid_valid;
    logic [WIDTH-1:0] main_q, skid_q;

    if (!depth_ok(DEPTH)) begin : g_bad_depth
        $error("pipe_stage_buf: DEPTH must be 1 or 2");
    end

    assign in_fire  = in_valid & in_ready;
    assign out_fire = main_valid & out_ready;

    // Main refills from skid when it holds the next entry, otherwise straight from upstream.
    assign main_load  = !flush & (main_valid ? out_fire & (skid_valid | in_fire) : in_fire);
    assign main_clear = flush | (out_fire & !skid_valid & !in_fire);

    pipe_slot #(.WIDTH(WIDTH)) u_main (
        .clk   (clk),
        .rst   (rst),
        .load  (main_load),
        .clear (main_clear),
        .d     (skid_valid ? skid_q : in_data),
        .valid (main_valid),
        .q     (main_q)
    );

    if (DEPTH == 2) begin : g_skid
        logic skid_load, skid_clear;
        assign skid_load  = !flush & in_fire & main_valid & !out_fire;
        assign skid_clear = flush | (skid_valid & out_fire);
        pipe_slot #(.WIDTH(WIDTH)) u_skid (
            .clk   (clk),
            .rst   (rst),
            .load  (skid_load),
            .clear (skid_clear),
            .d     (in_data),
            .valid (skid_valid),
            .q     (skid_q)
        );
        // Registered ready: breaks the combinational path back from out_ready.
        assign in_ready = !skid_valid;
    end else begin : g_reg
        assign skid_valid = 1'b0;
        assign skid_q     = '0;
        assign in_ready   = !main_valid | out_ready;
    end

    assign out_valid = main_valid;
    assign out_data  = main_q;
    assign occupancy = occ_t'({1'b0, main_valid}) + occ_t'({1'b0, skid_valid});

    always_ff @(posedge clk or posedge rst)
        if (rst)
            stall_cycles <= '0;
        else if (main_valid && !out_ready && !(&stall_cycles))
            stall_cycles <= stall_cycles + STALL_W'(1);

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: directed and scoreboarded checks of pipe_stage_buf for DEPTH=1 and DEPTH=2.
module tb_pipe_stage_buf;
    import pipe_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    logic        a_flush, a_in_valid, a_out_ready, a_in_ready, a_out_valid;
    logic [31:0] a_in_data, a_out_data;
    occ_t        a_occ;
    logic [15:0] a_stall;

    logic        b_flush, b_in_valid, b_out_ready, b_in_ready, b_out_valid;
    logic [31:0] b_in_data, b_out_data;
    occ_t        b_occ;
    logic [15:0] b_stall;

    logic        c_in_ready, c_out_valid;
    logic [31:0] c_out_data;
    occ_t        c_occ;
    logic [2:0]  c_stall;

    pipe_stage_buf #(.WIDTH(32), .DEPTH(1), .STALL_W(16)) dut_a (
        .clk(clk), .rst(rst), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .occupancy(a_occ), .stall_cycles(a_stall)
    );

    pipe_stage_buf #(.WIDTH(32), .DEPTH(2), .STALL_W(16)) dut_b (
        .clk(clk), .rst(rst), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .occupancy(b_occ), .stall_cycles(b_stall)
    );

    // Narrow stall counter twin of dut_b, fed the same stimulus.
    pipe_stage_buf #(.WIDTH(32), .DEPTH(2), .STALL_W(3)) dut_c (
        .clk(clk), .rst(rst), .flush(b_flush), .in_valid(b_in_valid), .in_ready(c_in_ready),
        .in_data(b_in_data), .out_valid(c_out_valid), .out_ready(b_out_ready), .out_data(c_out_data),
        .occupancy(c_occ), .stall_cycles(c_stall)
    );

    always @(negedge clk) begin
        checks += 5;
        assert (a_occ <= 2'd1) else begin fails++; $display("FAIL occ_bound_d1: occ=%0d max 1", a_occ); end
        assert (b_occ <= 2'd2) else begin fails++; $display("FAIL occ_bound_d2: occ=%0d max 2", b_occ); end
        assert (c_occ <= 2'd2) else begin fails++; $display("FAIL occ_bound_c: occ=%0d max 2", c_occ); end
        assert (a_out_valid || a_out_data == '0) else begin fails++; $display("FAIL bubble_d1: data=%h need 0", a_out_data); end
        assert (b_out_valid || b_out_data == '0) else begin fails++; $display("FAIL bubble_d2: data=%h need 0", b_out_data); end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_flush = 0; a_in_valid = 0; a_in_data = '0; a_out_ready = 0;
        b_flush = 0; b_in_valid = 0; b_in_data = '0; b_out_ready = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        #2;
        checks++;
        if (a_out_valid !== 1'b0 || a_out_data !== '0 || a_occ !== OCC_EMPTY || a_in_ready !== 1'b1 || a_stall !== '0) begin
            fails++;
            $display("FAIL reset_d1: valid=%b data=%h occ=%0d in_ready=%b stall=%0d need 0/0/0/1/0", a_out_valid, a_out_data, a_occ, a_in_ready, a_stall);
        end
        checks++;
        if (b_out_valid !== 1'b0 || b_out_data !== '0 || b_occ !== OCC_EMPTY || b_in_ready !== 1'b1 || b_stall !== '0) begin
            fails++;
            $display("FAIL reset_d2: valid=%b data=%h occ=%0d in_ready=%b stall=%0d need 0/0/0/1/0", b_out_valid, b_out_data, b_occ, b_in_ready, b_stall);
        end
        checks++;
        if (c_out_valid !== 1'b0 || c_occ !== OCC_EMPTY || c_in_ready !== 1'b1 || c_stall !== '0) begin
            fails++;
            $display("FAIL reset_c: valid=%b occ=%0d in_ready=%b stall=%0d need 0/0/1/0", c_out_valid, c_occ, c_in_ready, c_stall);
        end
        step();
        rst = 1'b0;
        #1;
        checks++;
        if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_release_ready: d1=%b d2=%b need 1/1", a_in_ready, b_in_ready);
        end
    endtask

    task automatic test_depth1();
        logic [31:0] v [3];
        v[0] = 32'h11; v[1] = 32'h22; v[2] = 32'h33;
        a_out_ready = 1;
        a_in_valid  = 1;
        for (int i = 0; i < 3; i++) begin
            a_in_data = v[i];
            #1;
            checks++;
            if (a_in_ready !== 1'b1) begin
                fails++;
                $display("FAIL d1_stream_ready[%0d]: in_ready=%b need 1", i, a_in_ready);
            end
            step();
            checks++;
            if (a_out_valid !== 1'b1 || a_out_data !== v[i] || a_occ !== OCC_ONE || a_stall !== '0) begin
                fails++;
                $display("FAIL d1_stream[%0d]: valid=%b data=%h occ=%0d stall=%0d need 1/%h/1/0", i, a_out_valid, a_out_data, a_occ, a_stall, v[i]);
            end
        end
        a_in_valid = 0;
        step();
        checks++;
        if (a_out_valid !== 1'b0 || a_out_data !== '0 || a_occ !== OCC_EMPTY) begin
            fails++;
            $display("FAIL d1_drain: valid=%b data=%h occ=%0d need 0/0/0", a_out_valid, a_out_data, a_occ);
        end
        a_out_ready = 0; a_in_valid = 1; a_in_data = 32'h44;
        step();
        a_in_valid = 0;
        #1;
        checks++;
        if (a_in_ready !== 1'b0) begin
            fails++;
            $display("FAIL d1_backpressure: in_ready=%b need 0", a_in_ready);
        end
        step();
        checks++;
        if (a_out_data !== 32'h44 || a_stall !== 16'd1) begin
            fails++;
            $display("FAIL d1_hold: data=%h stall=%0d need 44/1", a_out_data, a_stall);
        end
        a_out_ready = 1;
        #1;
        checks++;
        if (a_in_ready !== 1'b1) begin
            fails++;
            $display("FAIL d1_ready_comb: in_ready=%b need 1", a_in_ready);
        end
        a_flush = 1; a_in_valid = 1; a_in_data = 32'h88;
        step();
        a_flush = 0; a_in_valid = 0;
        checks++;
        if (a_out_valid !== 1'b0 || a_out_data !== '0 || a_occ !== OCC_EMPTY || a_stall !== 16'd1) begin
            fails++;
            $display("FAIL d1_flush: valid=%b data=%h occ=%0d stall=%0d need 0/0/0/1", a_out_valid, a_out_data, a_occ, a_stall);
        end
        a_out_ready = 0;
    endtask

    task automatic test_skid();
        b_out_ready = 0; b_in_valid = 1; b_in_data = 32'hA1;
        step();
        checks++;
        if (b_occ !== OCC_ONE || b_in_ready !== 1'b1 || b_out_data !== 32'hA1) begin
            fails++;
            $display("FAIL skid_one: occ=%0d in_ready=%b data=%h need 1/1/a1", b_occ, b_in_ready, b_out_data);
        end
        b_in_data = 32'hA2;
        step();
        b_in_valid = 0;
        checks++;
        if (b_occ !== OCC_FULL || b_in_ready !== 1'b0 || b_out_data !== 32'hA1) begin
            fails++;
            $display("FAIL skid_full: occ=%0d in_ready=%b data=%h need 2/0/a1", b_occ, b_in_ready, b_out_data);
        end
        b_out_ready = 1;
        #1;
        checks++;
        if (b_in_ready !== 1'b0) begin
            fails++;
            $display("FAIL skid_ready_comb: in_ready=%b need 0 before the edge", b_in_ready);
        end
        step();
        checks++;
        if (b_occ !== OCC_ONE || b_out_data !== 32'hA2 || b_in_ready !== 1'b1) begin
            fails++;
            $display("FAIL skid_pop1: occ=%0d data=%h in_ready=%b need 1/a2/1", b_occ, b_out_data, b_in_ready);
        end
        step();
        checks++;
        if (b_occ !== OCC_EMPTY || b_out_valid !== 1'b0 || b_out_data !== '0) begin
            fails++;
            $display("FAIL skid_pop2: occ=%0d valid=%b data=%h need 0/0/0", b_occ, b_out_valid, b_out_data);
        end
        b_in_valid = 1; b_in_data = 32'hC1;
        step();
        b_in_data = 32'hC2;
        step();
        b_in_valid = 0;
        checks++;
        if (b_occ !== OCC_ONE || b_out_data !== 32'hC2) begin
            fails++;
            $display("FAIL skid_passthru: occ=%0d data=%h need 1/c2", b_occ, b_out_data);
        end
        step();
        b_out_ready = 0;
    endtask

    task automatic test_stall();
        rst = 1; #2; rst = 0;
        b_out_ready = 0; b_in_valid = 1; b_in_data = 32'hD1;
        step();
        b_in_data = 32'hD2;
        step();
        b_in_valid = 0;
        checks++;
        if (b_occ !== OCC_FULL || b_stall !== 16'd1 || c_stall !== 3'd1) begin
            fails++;
            $display("FAIL stall_fill: occ=%0d stall=%0d stall3=%0d need 2/1/1", b_occ, b_stall, c_stall);
        end
        repeat (5) step();
        checks++;
        if (b_stall !== 16'd6 || c_stall !== 3'd6 || b_occ !== OCC_FULL) begin
            fails++;
            $display("FAIL stall_5: stall=%0d stall3=%0d occ=%0d need 6/6/2", b_stall, c_stall, b_occ);
        end
        repeat (5) step();
        checks++;
        if (b_stall !== 16'd11 || c_stall !== 3'd7) begin
            fails++;
            $display("FAIL stall_sat: stall=%0d stall3=%0d need 11/7", b_stall, c_stall);
        end
    endtask

    task automatic test_flush();
        b_out_ready = 1; b_flush = 1; b_in_valid = 1; b_in_data = 32'hFF;
        step();
        b_flush = 0; b_in_valid = 0;
        checks++;
        if (b_occ !== OCC_EMPTY || b_out_valid !== 1'b0 || b_out_data !== '0 || b_stall !== 16'd11) begin
            fails++;
            $display("FAIL flush_full: occ=%0d valid=%b data=%h stall=%0d need 0/0/0/11", b_occ, b_out_valid, b_out_data, b_stall);
        end
        step();
        checks++;
        if (b_out_valid !== 1'b0 || b_out_data !== '0) begin
            fails++;
            $display("FAIL flush_leak: valid=%b data=%h need 0/0", b_out_valid, b_out_data);
        end
        b_in_valid = 1; b_in_data = 32'h05;
        step();
        b_flush = 1; b_in_data = 32'hFF;
        #1;
        checks++;
        if (b_in_ready !== 1'b1 || b_out_data !== 32'h05) begin
            fails++;
            $display("FAIL flush_ready: in_ready=%b data=%h need 1/05", b_in_ready, b_out_data);
        end
        step();
        b_flush = 0; b_in_valid = 0;
        checks++;
        if (b_occ !== OCC_EMPTY || b_out_valid !== 1'b0 || b_out_data !== '0) begin
            fails++;
            $display("FAIL flush_one: occ=%0d valid=%b data=%h need 0/0/0", b_occ, b_out_valid, b_out_data);
        end
        step();
        checks++;
        if (b_out_valid !== 1'b0 || b_occ !== OCC_EMPTY) begin
            fails++;
            $display("FAIL flush_one_leak: valid=%b occ=%0d need 0/0", b_out_valid, b_occ);
        end
        b_out_ready = 0;
    endtask

    task automatic test_async_reset();
        b_out_ready = 0; b_in_valid = 1; b_in_data = 32'hBEEF;
        step();
        b_in_valid = 0;
        checks++;
        if (b_occ !== OCC_ONE || b_out_data !== 32'hBEEF) begin
            fails++;
            $display("FAIL areset_setup: occ=%0d data=%h need 1/beef", b_occ, b_out_data);
        end
        #2;
        rst = 1;
        #1;
        checks++;
        if (b_out_valid !== 1'b0 || b_out_data !== '0 || b_occ !== OCC_EMPTY || b_stall !== '0 || c_stall !== '0) begin
            fails++;
            $display("FAIL areset_async: valid=%b data=%h occ=%0d stall=%0d stall3=%0d need 0/0/0/0/0", b_out_valid, b_out_data, b_occ, b_stall, c_stall);
        end
        step();
        rst = 0;
        #1;
        checks++;
        if (b_in_ready !== 1'b1 || b_out_valid !== 1'b0) begin
            fails++;
            $display("FAIL areset_release: in_ready=%b valid=%b need 1/0", b_in_ready, b_out_valid);
        end
    endtask

    task automatic test_random();
        logic [31:0] qa [$];
        logic [31:0] qb [$];
        logic [31:0] exp_d;
        rst = 1; #2; rst = 0;
        for (int i = 0; i < 10000; i++) begin
            a_in_valid = $urandom_range(0, 1) != 0; a_in_data = $urandom(); a_out_ready = $urandom_range(0, 3) != 0;
            b_in_valid = $urandom_range(0, 2) != 0; b_in_data = $urandom(); b_out_ready = $urandom_range(0, 2) != 0;
            #1;
            checks += 2;
            if (int'(a_occ) != qa.size()) begin fails++; $display("FAIL rand_occ_d1 @%0d: occ=%0d need %0d", i, a_occ, qa.size()); end
            if (int'(b_occ) != qb.size()) begin fails++; $display("FAIL rand_occ_d2 @%0d: occ=%0d need %0d", i, b_occ, qb.size()); end
            if (a_out_valid && a_out_ready) begin
                checks++;
                if (qa.size() == 0) begin fails++; $display("FAIL rand_dup_d1 @%0d: data=%h with nothing pending", i, a_out_data); end
                else begin
                    exp_d = qa.pop_front();
                    if (a_out_data !== exp_d) begin fails++; $display("FAIL rand_data_d1 @%0d: data=%h need %h", i, a_out_data, exp_d); end
                end
            end
            if (b_out_valid && b_out_ready) begin
                checks++;
                if (qb.size() == 0) begin fails++; $display("FAIL rand_dup_d2 @%0d: data=%h with nothing pending", i, b_out_data); end
                else begin
                    exp_d = qb.pop_front();
                    if (b_out_data !== exp_d) begin fails++; $display("FAIL rand_data_d2 @%0d: data=%h need %h", i, b_out_data, exp_d); end
                end
            end
            if (a_in_valid && a_in_ready) qa.push_back(a_in_data);
            if (b_in_valid && b_in_ready) qb.push_back(b_in_data);
            @(posedge clk);
            #1;
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_depth1();
        test_skid();
        test_stall();
        test_flush();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
